// File: rtl/spi_pkg.sv
// Shared types and reset constants for the SPI mode-0 master shift engine.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } spi_state_e;

    localparam logic CS_N_RST = 1'b1;
    localparam logic SCLK_RST = 1'b0;

endpackage

// File: rtl/spi_shift_engine_sva.sv
// Protocol checker bound into spi_shift_engine: the divider strobes must never coincide.
`ifndef SYNTHESIS
module spi_shift_engine_sva (
    input logic clk_i,
    input logic arst_i,
    input logic div_pos_i,
    input logic div_neg_i
);

    // Both divided-clock edge strobes in one cycle means the divider is broken.
    a_no_dual_strobe: assert property (@(posedge clk_i) disable iff (arst_i)
        !(div_pos_i && div_neg_i));

endmodule

bind spi_shift_engine spi_shift_engine_sva u_sva (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .div_pos_i (div_pos_i),
    .div_neg_i (div_neg_i)
);
`endif

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master: gates the free-running divided clock onto SCLK, drives CS_n/MOSI,
// samples MISO, and hands whole frames to/from the upstream valid/ready interface.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CS_GAP = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              div_pos_i,
    input  logic              div_neg_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    spi_state_e        state_q, state_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic              handshake_s;

    assign handshake_s = tx_valid_i & tx_ready_q;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;

        case (state_q)
            IDLE: begin
                if (handshake_s) begin
                    tx_sr_d = tx_data_i;
                    rx_sr_d = {DATA_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ALIGN;
                end else begin
                    state_d = IDLE;
                end
            end
            // CS_n drops on a falling divided edge so MOSI gets half a period of setup.
            ALIGN: begin
                if (div_neg_i) begin
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_sr_q[DATA_W-1];
                    state_d = SHIFT;
                end else begin
                    state_d = ALIGN;
                end
            end
            SHIFT: begin
                if (div_pos_i) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_i};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (div_neg_i) begin
                    sclk_d = 1'b0;
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        cs_n_d     = 1'b1;
                        mosi_d     = 1'b0;
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        gap_d      = {GAP_W{1'b0}};
                        state_d    = GAP;
                    end else begin
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        mosi_d  = tx_sr_q[DATA_W-2];
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            GAP: begin
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                if (div_neg_i) begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_q + GAP_W'(1) == GAP_W'(CS_GAP)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = SCLK_RST;
                cs_n_d  = CS_N_RST;
                mosi_d  = 1'b0;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            sclk_q     <= SCLK_RST;
            cs_n_q     <= CS_N_RST;
            mosi_q     <= 1'b0;
            rx_data_q  <= {DATA_W{1'b0}};
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            tx_sr_q    <= {DATA_W{1'b0}};
            rx_sr_q    <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign sclk_o     = sclk_q;
    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a behavioural CLK_DIV=2 divider (SCLK = 4 clk_i).
module tb_spi_shift_engine;

    logic       clk_i = 1'b0;
    logic       arst_i = 1'b1;
    logic [1:0] ph = 2'd0;
    logic       div_pos_i, div_neg_i, clk_div;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, busy_o, sclk_o, cs_n_o, mosi_o, miso_i;
    logic       miso_one = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int         rise_n = 0, cs_low_n = 0, mosi_hi_n = 0, rxv_n = 0;
    logic       sclk_prev = 1'b0;
    logic [7:0] mosi_bits = 8'h00;

    logic [7:0] r;
    int         b_rise, b_cs, b_mhi, b_rxv, k, n;
    logic       pv;

    spi_shift_engine #(.DATA_W(8), .CS_GAP(1)) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .div_pos_i  (div_pos_i),
        .div_neg_i  (div_neg_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .sclk_o     (sclk_o),
        .cs_n_o     (cs_n_o),
        .mosi_o     (mosi_o),
        .miso_i     (miso_i)
    );

    always #5 clk_i = ~clk_i;

    // Free-running divider: divided clock high for ph 2..3, strobes one cycle ahead of each edge.
    always @(posedge clk_i) ph <= ph + 2'd1;
    assign clk_div   = ph[1];
    assign div_pos_i = (ph == 2'd1);
    assign div_neg_i = (ph == 2'd3);
    assign miso_i    = miso_one ? 1'b1 : mosi_o;

    always @(negedge clk_i) begin
        if (sclk_o && !sclk_prev) begin
            rise_n    = rise_n + 1;
            mosi_bits = {mosi_bits[6:0], mosi_o};
        end
        sclk_prev = sclk_o;
        if (!cs_n_o) cs_low_n = cs_low_n + 1;
        if (mosi_o) mosi_hi_n = mosi_hi_n + 1;
        if (rx_valid_o) rxv_n = rxv_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk_i);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        while (!tx_ready_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("send_ready", {31'd0, tx_ready_o}, 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_rx(output logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!rx_valid_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("rx_strobe", {31'd0, rx_valid_o}, 32'd1);
        d = rx_data_o;
    endtask

    task automatic wait_ready(output int cycles);
        int t;
        t = 0;
        while (!tx_ready_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        cycles = t;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check_eq("rst_sclk", {31'd0, sclk_o}, 32'd0);
        check_eq("rst_csn", {31'd0, cs_n_o}, 32'd1);
        check_eq("rst_mosi", {31'd0, mosi_o}, 32'd0);
        check_eq("rst_ready", {31'd0, tx_ready_o}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_rxv", {31'd0, rx_valid_o}, 32'd0);
        check_eq("rst_rxd", {24'd0, rx_data_o}, 32'd0);
        @(negedge clk_i);
        arst_i = 1'b0;

        // T1: loopback 0xA5
        b_rise = rise_n; b_cs = cs_low_n; b_rxv = rxv_n;
        send(8'hA5);
        wait_rx(r);
        check_eq("t1_rx", {24'd0, r}, 32'hA5);
        check_eq("t1_rises", rise_n - b_rise, 32'd8);
        check_eq("t1_mosi", {24'd0, mosi_bits}, 32'hA5);
        check_eq("t1_cs_low", cs_low_n - b_cs, 32'd32);
        check_eq("t1_csn_end", {31'd0, cs_n_o}, 32'd1);
        wait_ready(k);
        check_eq("t1_gap", k, 32'd4);
        check_eq("t1_rxv_once", rxv_n - b_rxv, 32'd1);

        // T2: MISO tied high, send zeros
        miso_one = 1'b1;
        b_mhi = mosi_hi_n;
        send(8'h00);
        wait_rx(r);
        check_eq("t2_rx", {24'd0, r}, 32'hFF);
        check_eq("t2_mosi_hi", mosi_hi_n - b_mhi, 32'd0);
        wait_ready(k);
        check_eq("t2_gap", k, 32'd4);
        miso_one = 1'b0;

        // T3: valid held high across two frames
        @(negedge clk_i);
        tx_data_i  = 8'h3C;
        tx_valid_i = 1'b1;
        k = 0;
        while (!tx_ready_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        tx_data_i = 8'hC3;
        wait_rx(r);
        check_eq("t3_rx0", {24'd0, r}, 32'h3C);
        k = 0;
        while (cs_n_o && k < 100) begin
            k++;
            @(negedge clk_i);
        end
        check_eq("t3_cs_high", k, 32'd8);
        wait_rx(r);
        tx_valid_i = 1'b0;
        check_eq("t3_rx1", {24'd0, r}, 32'hC3);
        wait_ready(k);
        repeat (10) @(negedge clk_i);
        check_eq("t3_idle", {31'd0, busy_o}, 32'd0);

        // T4: reset after 4th SCLK rise
        b_rxv = rxv_n;
        send(8'h5A);
        k = 0; n = 0; pv = sclk_o;
        while (n < 4 && k < 200) begin
            @(negedge clk_i);
            if (sclk_o && !pv) n++;
            pv = sclk_o;
            k++;
        end
        check_eq("t4_rises", n, 32'd4);
        #1 arst_i = 1'b1;
        #1;
        check_eq("t4_sclk", {31'd0, sclk_o}, 32'd0);
        check_eq("t4_csn", {31'd0, cs_n_o}, 32'd1);
        check_eq("t4_mosi", {31'd0, mosi_o}, 32'd0);
        check_eq("t4_ready", {31'd0, tx_ready_o}, 32'd1);
        check_eq("t4_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        arst_i = 1'b0;
        repeat (60) @(negedge clk_i);
        check_eq("t4_no_rxv", rxv_n - b_rxv, 32'd0);
        send(8'h81);
        wait_rx(r);
        check_eq("t4_rx", {24'd0, r}, 32'h81);
        wait_ready(k);

        // T5: handshake while divided clock is high
        b_rise = rise_n;
        k = 0;
        @(negedge clk_i);
        while (!(tx_ready_o && ph == 2'd2) && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        tx_data_i  = 8'h96;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        check_eq("t5_cs_hold", {31'd0, cs_n_o}, 32'd1);
        check_eq("t5_sclk_a", {31'd0, sclk_o}, 32'd0);
        @(negedge clk_i);
        check_eq("t5_cs_fall", {31'd0, cs_n_o}, 32'd0);
        check_eq("t5_div_low", {31'd0, clk_div}, 32'd0);
        check_eq("t5_sclk_b", {31'd0, sclk_o}, 32'd0);
        wait_rx(r);
        check_eq("t5_rx", {24'd0, r}, 32'h96);
        check_eq("t5_rises", rise_n - b_rise, 32'd8);
        wait_ready(k);

        // T6: request during SHIFT is not consumed until IDLE
        b_rise = rise_n;
        send(8'h4E);
        k = 0; n = 0; pv = sclk_o;
        while (n < 3 && k < 200) begin
            @(negedge clk_i);
            if (sclk_o && !pv) n++;
            pv = sclk_o;
            k++;
        end
        tx_data_i  = 8'hFF;
        tx_valid_i = 1'b1;
        wait_rx(r);
        check_eq("t6_rx0", {24'd0, r}, 32'h4E);
        check_eq("t6_mosi0", {24'd0, mosi_bits}, 32'h4E);
        check_eq("t6_not_ready", {31'd0, tx_ready_o}, 32'd0);
        wait_rx(r);
        tx_valid_i = 1'b0;
        check_eq("t6_rx1", {24'd0, r}, 32'hFF);
        check_eq("t6_rises", rise_n - b_rise, 32'd16);
        wait_ready(k);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
